key_device: RTL and testbench
=============================

# key_device

Memory-mapped pushbutton input device on the processor's shared address/data bus: the read-side counterpart of the bus output devices. It synchronizes and debounces a 4-bit key vector. Each debounced change is latched into a data register, a ready flag is set, and an interrupt is raised when enabled. The CPU polls or takes the interrupt, reads the key state through the bidirectional data bus, and acknowledges the event with that read.

## Interface
- BITS, 32, width of ABUS/DBUS
- BASE, 32'hF0000010, address of KDATA; KCTRL is at BASE+4
- DEBOUNCE, 100000, cycles a new synchronized key value must stay stable before it is accepted (≥2)
- CLK  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- ABUS  in  BITS  bus address
- DBUS  inout  BITS  bus data; driven only on selected reads, else all-Z
- WE  in  1  1 = bus write cycle, 0 = read
- key  in  4  raw asynchronous keys, 1 = pressed (top level inverts board polarity)
- INTR  out  1  interrupt request, level

## Operation
- Registers:
  - KDATA (BASE): read-only; bits [3:0] = debounced key state, upper bits 0.
  - KCTRL (BASE+4): bit0 Ready, bit2 Overrun, bit8 IE; other bits read 0.
- Bus reads:
  - Read of KDATA or KCTRL (address match, WE=0) drives DBUS combinationally with the register value.
  - Any other address or WE=1 leaves DBUS all-Z.
- Writes:
  - KDATA: ignored.
  - KCTRL:
    - Ready: writing 0 clears it; writing 1 is ignored.
    - Overrun: writing 0 clears it; writing 1 is ignored.
    - IE takes DBUS[8].
- Read side effect: a KDATA read clears Ready at the clock edge ending the cycle.
- Input path:
  - key passes a 2-flop synchronizer (sync1 → sync2).
  - cand holds the candidate value; cnt is a saturating stability counter, ceil(log2 DEBOUNCE) bits.
  - If sync2 ≠ cand: cand ← sync2, cnt ← 0.
  - Else, if cnt < DEBOUNCE-1: cnt ← cnt+1.
  - Else (cnt = DEBOUNCE-1) and cand ≠ KDATA: KDATA ← cand and an event fires.
- Event:
  - Ready ← 1.
  - If Ready was 1 and is not being cleared by a KDATA read in the same cycle: Overrun ← 1.
- Simultaneous events:
  - Event + KDATA read: the read returns the old KDATA; afterwards Ready = 1 and Overrun is unchanged.
  - Event + KCTRL write of Ready=0 or Overrun=0: the event's set wins.
  - IE is always updated by a KCTRL write.
- INTR = Ready & IE, combinational from registers.

## Timing
- Reset (synchronous) clears sync1, sync2, cand, cnt, KDATA, Ready, Overrun and IE to 0. INTR = 0 and DBUS = Z unless a read is selected.
- Reset asserted mid-debounce discards the pending candidate. It takes priority over bus writes and events in the same cycle.
- Latency: if key changes before edge E0 and stays stable, KDATA and Ready update at edge E(DEBOUNCE+2):
  - sync1 at E0
  - sync2 at E1
  - cand at E2
  - cnt reaches DEBOUNCE-1 at E(DEBOUNCE+1)
- A change lasting fewer than DEBOUNCE consecutive sync2 cycles never reaches KDATA.
- A key value returning to the current KDATA produces no event.
- Read data valid in the same cycle the address is presented (zero wait states); register side effects at that cycle's posedge.
- cnt saturates at DEBOUNCE-1 and never wraps.

## Test plan
(BITS=32, BASE=32'hF0000010, DEBOUNCE=4)
- Reset, then read F0000010 and F0000014 → both 0; INTR=0; DBUS Z when ABUS=0.
- key 0000→0101 before E0, held → KDATA=5 and Ready=1 exactly at E6, not at E5. Read KDATA → 5; next KCTRL read → 0.
- Write F0000014=32'h100, then key 0101→0001 → INTR rises with Ready. KDATA read → INTR drops the following cycle.
- Two accepted changes (→0010 then →0011) with no read in between → KCTRL = 32'h5 (IE=0). Write KCTRL=0 → reads 0.
- 3-cycle glitch key 0000→1000→0000 → no event; KDATA stays 0.
- Event edge coincides with a KDATA read → read returns the old value; afterwards Ready=1, Overrun=0. Reset asserted while cnt=2 → all registers 0, no event later.

Source files
------------

// File: rtl/key_device.sv
// Memory-mapped debounced key input: 2-flop sync, stability counter, KDATA/KCTRL
// registers on the shared bus, and a level interrupt gated by IE.

module key_sync (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

module key_device #(
    parameter int               BITS     = 32,
    parameter logic [BITS-1:0]  BASE     = 32'hF0000010,
    parameter int               DEBOUNCE = 100000,
    parameter int               NUM_KEYS = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [BITS-1:0]     ABUS,
    inout  wire logic [BITS-1:0] DBUS,
    input  logic                WE,
    input  logic [NUM_KEYS-1:0] key,
    output logic                INTR
);
    localparam int              CW        = $clog2(DEBOUNCE);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE - 1);
    localparam logic [BITS-1:0] CTRL_ADDR = BASE + BITS'(4);

    typedef struct packed {
        logic rd_data;
        logic rd_ctrl;
        logic wr_ctrl;
    } bus_req_t;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } ctrl_t;

    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] cand;
    logic [NUM_KEYS-1:0] kdata;
    logic [CW-1:0]       cnt;
    ctrl_t               ctrl, ctrl_nxt;
    bus_req_t            req;
    logic                accept;
    logic [BITS-1:0]     rdata;
    logic [BITS-1:0]     dbus_unused;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
        key_sync u_sync (
            .CLK   (CLK),
            .reset (reset),
            .d     (key[i]),
            .q     (sync2[i])
        );
    end

    // Only bits 0, 2 and 8 of a KCTRL write carry meaning.
    assign dbus_unused = DBUS;

    always_comb begin
        req         = '0;
        req.rd_data = (ABUS == BASE) && !WE;
        req.rd_ctrl = (ABUS == CTRL_ADDR) && !WE;
        req.wr_ctrl = (ABUS == CTRL_ADDR) && WE;
    end

    // Candidate has been stable long enough and differs from what the CPU sees.
    assign accept = (sync2 == cand) && (cnt == CNT_MAX) && (cand != kdata);

    always_comb begin
        ctrl_nxt = ctrl;
        if (req.rd_data)
            ctrl_nxt.ready = 1'b0;
        if (req.wr_ctrl) begin
            if (!DBUS[0]) ctrl_nxt.ready   = 1'b0;
            if (!DBUS[2]) ctrl_nxt.overrun = 1'b0;
            ctrl_nxt.ie = DBUS[8];
        end
        // An event's set outranks any clear landing in the same cycle.
        if (accept) begin
            ctrl_nxt.ready = 1'b1;
            if (ctrl.ready && !req.rd_data)
                ctrl_nxt.overrun = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cand  <= '0;
            cnt   <= '0;
            kdata <= '0;
            ctrl  <= '0;
        end else begin
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (accept)
                kdata <= cand;
            ctrl <= ctrl_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        if (req.rd_data) begin
            rdata[NUM_KEYS-1:0] = kdata;
        end else if (req.rd_ctrl) begin
            rdata[0] = ctrl.ready;
            rdata[2] = ctrl.overrun;
            rdata[8] = ctrl.ie;
        end
    end

    assign DBUS = (req.rd_data || req.rd_ctrl) ? rdata : 'z;
    assign INTR = ctrl.ready & ctrl.ie;
endmodule

// File: tb/tb_key_device.sv
// Randomized bench for key_device against a run-length behavioural model,
// preceded by directed scenarios with literal expectations.

module tb_key_device;
    localparam int          BITS  = 32;
    localparam logic [31:0] BASE  = 32'hF0000010;
    localparam logic [31:0] CTRLA = 32'hF0000014;
    localparam int          DEB   = 4;
    localparam logic [31:0] REL   = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] abus = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic        tb_drv = 1'b0;
    logic [3:0]  key = '0;
    wire  [31:0] DBUS;
    logic        INTR;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    // Model: what the CPU-visible state must be after each edge.
    logic [3:0] m_s1, m_s2, m_kdata;
    logic       m_ready, m_over, m_ie;
    logic [3:0] hist[$];

    assign DBUS = tb_drv ? wd : 'z;
    for (genvar i = 0; i < BITS; i++) begin : g_pu
        pullup pu (DBUS[i]);
    end

    key_device #(.BITS(BITS), .BASE(BASE), .DEBOUNCE(DEB), .NUM_KEYS(4)) dut (
        .CLK   (CLK),
        .reset (reset),
        .ABUS  (abus),
        .DBUS  (DBUS),
        .WE    (we),
        .key   (key),
        .INTR  (INTR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // A change is accepted once sync2 has held the same value for DEB+1
    // consecutive samples and that value differs from the published one.
    task automatic model_step();
        logic rd_d, wr_c, ev;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_kdata = '0;
            m_ready = 0; m_over = 0; m_ie = 0;
            hist.delete();
            return;
        end
        hist.push_back(m_s2);
        if (hist.size() > DEB + 1) void'(hist.pop_front());
        ev = 1'b0;
        if (hist.size() == DEB + 1) begin
            ev = (hist[0] != m_kdata);
            foreach (hist[i]) if (hist[i] != hist[0]) ev = 1'b0;
        end
        rd_d = (abus == BASE) && !we;
        wr_c = (abus == CTRLA) && we;
        if (wr_c) begin
            if (!wd[2]) m_over = 1'b0;
            m_ie = wd[8];
        end
        if (ev) begin
            if (m_ready && !rd_d) m_over = 1'b1;
            m_ready = 1'b1;
            m_kdata = hist[0];
        end else if (rd_d || (wr_c && !wd[0])) begin
            m_ready = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = key;
    endtask

    // Advance one edge; inputs return to idle just after it.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        abus = '0; we = 1'b0; tb_drv = 1'b0; wd = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        abus = a; we = 1'b0;
        #2 chk(name, DBUS, exp);
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        abus = a; we = 1'b1; wd = d; tb_drv = 1'b1;
        tick();
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("intr", {31'b0, INTR}, {31'b0, m_ready & m_ie});
            if (!tb_drv) begin
                if (abus == BASE && !we)
                    chk("dbus_kdata", DBUS, {28'b0, m_kdata});
                else if (abus == CTRLA && !we)
                    chk("dbus_kctrl", DBUS, {23'b0, m_ie, 5'b0, m_over, 1'b0, m_ready});
                else
                    chk("dbus_release", DBUS, REL);
            end
        end
    end

    initial begin
        int op, hold;
        #1;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        rd_lit("rst_kdata", BASE, 32'h0);
        rd_lit("rst_kctrl", CTRLA, 32'h0);
        chk("rst_intr", {31'b0, INTR}, 32'h0);
        abus = 32'h0;
        #1 chk("rst_release", DBUS, REL);

        // Acceptance latency: visible after E6, not after E5
        key = 4'b0101;
        ticks(6);
        rd_lit("lat_not_e5", CTRLA, 32'h0);
        rd_lit("lat_e6_ready", CTRLA, 32'h1);
        rd_lit("lat_kdata", BASE, 32'h5);
        rd_lit("lat_ack", CTRLA, 32'h0);

        // Interrupt enable and acknowledge by KDATA read
        wr(CTRLA, 32'h100);
        key = 4'b0001;
        ticks(7);
        chk("ie_intr_up", {31'b0, INTR}, 32'h1);
        rd_lit("ie_kctrl", CTRLA, 32'h101);
        rd_lit("ie_kdata", BASE, 32'h1);
        chk("ie_intr_down", {31'b0, INTR}, 32'h0);

        // Overrun from two unread events
        wr(CTRLA, 32'h0);
        key = 4'b0010; ticks(8);
        key = 4'b0011; ticks(8);
        rd_lit("ovr_kctrl", CTRLA, 32'h5);
        wr(CTRLA, 32'h0);
        rd_lit("ovr_clear", CTRLA, 32'h0);

        // Short glitch is filtered
        key = 4'b0000; ticks(8);
        rd_lit("gl_pre", BASE, 32'h0);
        key = 4'b1000; ticks(3);
        key = 4'b0000; ticks(10);
        rd_lit("gl_kctrl", CTRLA, 32'h0);
        rd_lit("gl_kdata", BASE, 32'h0);

        // Event coinciding with a KDATA read while Ready already set
        key = 4'b0110; ticks(8);
        key = 4'b0111; ticks(6);
        rd_lit("co_old", BASE, 32'h6);
        rd_lit("co_kctrl", CTRLA, 32'h1);
        rd_lit("co_new", BASE, 32'h7);

        // Reset mid-debounce drops the candidate
        wr(CTRLA, 32'h100);
        key = 4'b1001; ticks(5);
        reset = 1'b1; key = 4'b0000;
        tick();
        reset = 1'b0;
        ticks(10);
        rd_lit("mr_kctrl", CTRLA, 32'h0);
        rd_lit("mr_kdata", BASE, 32'h0);

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                key = 4'($urandom);
                hold = $urandom_range(1, 10);
            end
            hold--;
            reset = ($urandom_range(0, 299) == 0);
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin abus = BASE; we = 1'b0; end
                2, 3: begin abus = CTRLA; we = 1'b0; end
                4: begin abus = CTRLA; we = 1'b1; tb_drv = 1'b1; wd = $urandom; end
                5: begin abus = BASE; we = 1'b1; tb_drv = 1'b1; wd = $urandom; end
                6: begin abus = BASE + 32'h8; we = 1'b0; end
                7: begin abus = BASE - 32'h4; we = 1'b0; end
                default: begin abus = $urandom; we = $urandom_range(0, 1); end
            endcase
            if (abus == BASE || abus == CTRLA) tb_drv = we;
            tick();
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
